// File: rtl/hamming_pkg.sv
// Shared types, flag encodings and parity helpers for the SECDED Hamming(16,11) engine.
package hamming_pkg;

  localparam int DATA_W = 11;
  localparam int CODE_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RDL  = 3'd1,
    ST_RDH  = 3'd2,
    ST_CALC = 3'd3,
    ST_WRL  = 3'd4,
    ST_WRH  = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  typedef enum logic {
    MODE_ENCODE = 1'b0,
    MODE_DECODE = 1'b1
  } mode_t;

  localparam logic [1:0] FLAG_CLEAN = 2'b00;
  localparam logic [1:0] FLAG_SEC   = 2'b01;
  localparam logic [1:0] FLAG_DED   = 2'b10;

  // Returns {p8, p4, p2, p1} for data bits d[11:1].
  function automatic logic [3:0] calc_parity(input logic [11:1] d);
    logic p8, p4, p2, p1;
    p8 = ^d[11:5];
    p4 = (^d[11:8]) ^ (^d[4:2]);
    p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p1 = d[11] ^ d[9]  ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    return {p8, p4, p2, p1};
  endfunction

  // Hamming position of data bit d_i: d1 sits at 3, d2..d4 at 5..7, d5..d11 at 9..15.
  function automatic logic [3:0] data_pos(input int unsigned i);
    if (i == 1)      return 4'd3;
    else if (i <= 4) return 4'(i + 3);
    else             return 4'(i + 4);
  endfunction

endpackage

// File: rtl/hamming_engine_if.sv
// Host/memory bundle of the Hamming engine: job request, status and byte-wide data memory.
interface hamming_engine_if #(
  parameter int ADDR_W = 8
) ();

  logic                  req;
  hamming_pkg::mode_t    mode;
  logic [ADDR_W-1:0]     src_base;
  logic [ADDR_W-1:0]     dst_base;
  logic [ADDR_W-1:0]     mem_addr;
  logic [7:0]            mem_wdata;
  logic                  mem_we;
  logic [7:0]            mem_rdata;
  logic                  busy;
  logic                  ack;
  logic [7:0]            sec_cnt;
  logic [7:0]            ded_cnt;

  // Host side: issues jobs and answers memory reads.
  modport master (
    output req, mode, src_base, dst_base, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, busy, ack, sec_cnt, ded_cnt
  );

  // Engine side.
  modport slave (
    input  req, mode, src_base, dst_base, mem_rdata,
    output mem_addr, mem_wdata, mem_we, busy, ack, sec_cnt, ded_cnt
  );

endinterface

// File: rtl/hamming_core.sv
// Combinational SECDED core: 11-bit data -> 16-bit codeword, and 16-bit codeword -> corrected data + flag.
module hamming_core
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] enc_data,
  output logic [CODE_W-1:0] enc_code,
  input  logic [CODE_W-1:0] dec_code,
  output logic [DATA_W-1:0] dec_data,
  output logic [1:0]        dec_flag
);

  logic [11:1] enc_d;
  logic [3:0]  enc_p;

  assign enc_d = enc_data;
  assign enc_p = calc_parity(enc_d);

  // Bit k of the codeword is Hamming position k; bit 0 carries overall parity p16.
  assign enc_code = {enc_d[11:5], enc_p[3], enc_d[4:2], enc_p[2], enc_d[1],
                     enc_p[1], enc_p[0], ^{enc_d, enc_p}};

  logic [11:1] rx_d;
  logic [3:0]  syn;
  logic        q;

  assign rx_d = {dec_code[15:9], dec_code[7:5], dec_code[3]};
  assign syn  = {dec_code[8], dec_code[4], dec_code[2], dec_code[1]} ^ calc_parity(rx_d);
  assign q    = ^dec_code;

  // A single error at a parity position (or at p16 when syn is 0) leaves data untouched.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
    dec_data = rx_d;
    dec_flag = FLAG_CLEAN;
    if (q) begin
      dec_flag = FLAG_SEC;
      for (int i = 1; i <= DATA_W; i++) begin
        if (syn == data_pos(i)) dec_data[i-1] = ~rx_d[i];
      end
    end else if (syn != 4'd0) begin
      dec_flag = FLAG_DED;
    end
  end

endmodule

// File: rtl/hamming_engine.sv
// Memory-to-memory SECDED job engine: reads MSG_COUNT 16-bit messages, encodes or corrects each, writes them back.
module hamming_engine
  import hamming_pkg::*;
#(
  parameter int MSG_COUNT = 15,
  parameter int ADDR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  hamming_engine_if.slave  bus
);

  localparam logic [6:0]        LAST_IDX = 7'(MSG_COUNT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state;
  logic [6:0]        idx;
  mode_t             mode_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [7:0]        lo_q;
  logic [15:0]       res_q;
  logic [7:0]        sec_q;
  logic [7:0]        ded_q;

  logic [ADDR_W-1:0] offset;
  logic [CODE_W-1:0] enc_code;
  logic [DATA_W-1:0] dec_data;
  logic [1:0]        dec_flag;

  assign offset = ADDR_W'({idx, 1'b0});

  // The high byte is consumed straight off mem_rdata in CALC, so only the low byte is held.
  hamming_core u_core (
    .enc_data (DATA_W'({bus.mem_rdata[2:0], lo_q})),
    .enc_code (enc_code),
    .dec_code ({bus.mem_rdata, lo_q}),
    .dec_data (dec_data),
    .dec_flag (dec_flag)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state  <= ST_IDLE;
      idx    <= '0;
      mode_q <= MODE_ENCODE;
      src_q  <= '0;
      dst_q  <= '0;
      lo_q   <= '0;
      res_q  <= '0;
      sec_q  <= '0;
      ded_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            state  <= ST_RDL;
            idx    <= '0;
            mode_q <= bus.mode;
            src_q  <= bus.src_base;
            dst_q  <= bus.dst_base;
            sec_q  <= '0;
            ded_q  <= '0;
          end
        end
        ST_RDL: state <= ST_RDH;
        ST_RDH: begin
          lo_q  <= bus.mem_rdata;
          state <= ST_CALC;
        end
        ST_CALC: begin
          if (mode_q == MODE_ENCODE) begin
            res_q <= enc_code;
          end else begin
            res_q <= {dec_flag, 3'b000, dec_data};
            if (dec_flag == FLAG_SEC && sec_q != 8'hFF) sec_q <= sec_q + 8'd1;
            if (dec_flag == FLAG_DED && ded_q != 8'hFF) ded_q <= ded_q + 8'd1;
          end
          state <= ST_WRL;
        end
        ST_WRL: state <= ST_WRH;
        ST_WRH: begin
          if (idx == LAST_IDX) begin
            state <= ST_DONE;
          end else begin
            idx   <= idx + 7'd1;
            state <= ST_RDL;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Addresses outside the read/write states are parked at 0 so reset values hold while idle.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      ST_RDL: bus.mem_addr = src_q + offset;
      ST_RDH: bus.mem_addr = src_q + offset + ADDR_ONE;
      ST_WRL: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = dst_q + offset;
        bus.mem_wdata = res_q[7:0];
      end
      ST_WRH: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = dst_q + offset + ADDR_ONE;
        bus.mem_wdata = res_q[15:8];
      end
      default: ;
    endcase
  end

  assign bus.busy    = (state != ST_IDLE);
  assign bus.ack     = (state == ST_DONE);
  assign bus.sec_cnt = sec_q;
  assign bus.ded_cnt = ded_q;

endmodule

// File: tb/tb_hamming_engine.sv
// Scoreboard bench for hamming_engine: positional Hamming reference model, bench-owned byte memory.
module tb_hamming_engine;
  import hamming_pkg::*;

  localparam int M  = 3;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hamming_engine_if #(.ADDR_W(AW)) bus ();

  hamming_engine #(.MSG_COUNT(M), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Bench memory: synchronous read, plus a bench-side write port used only while the DUT is idle.
  logic [7:0] mem [256];
  logic       tb_we;
  logic [7:0] tb_addr, tb_data;

  always @(posedge clk) begin
    if (tb_we)           mem[tb_addr] <= tb_data;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int cyc; logic [7:0] sec; logic [7:0] ded; } ack_t;

  wr_t        wq[$];
  ack_t       aq[$];
  logic [7:0] ref_mem [256];
  logic [7:0] last_sec, last_ded;
  int         n_cmp = 0, n_bad = 0, writes_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_encode(input logic [10:0] d);
    logic [15:0] cw;
    int di;
    cw = '0;
    di = 0;
    for (int k = 1; k < 16; k++) begin
      if ((k & (k - 1)) != 0) begin
        cw[k] = d[di];
        di++;
      end
    end
    for (int j = 0; j < 4; j++) begin
      logic p;
      p = 1'b0;
      for (int k = 1; k < 16; k++)
        if (((k >> j) & 1) == 1 && k != (1 << j)) p ^= cw[k];
      cw[1 << j] = p;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  // Returns {flag, data[10:0]}.
  function automatic logic [12:0] ref_decode(input logic [15:0] cw_in);
    logic [15:0] cw;
    logic [10:0] d;
    logic [1:0]  fl;
    int s, di;
    cw = cw_in;
    s  = 0;
    for (int k = 1; k < 16; k++) if (cw[k]) s ^= k;
    if (^cw) begin
      cw[s] = ~cw[s];
      fl = FLAG_SEC;
    end else if (s != 0) fl = FLAG_DED;
    else fl = FLAG_CLEAN;
    di = 0;
    d  = '0;
    for (int k = 1; k < 16; k++) begin
      if ((k & (k - 1)) != 0) begin
        d[di] = cw[k];
        di++;
      end
    end
    return {fl, d};
  endfunction

  task automatic model_job(input logic m, input logic [7:0] src, input logic [7:0] dst,
                           output logic [7:0] sec, output logic [7:0] ded);
    logic [7:0]  a, lo, hi;
    logic [15:0] out;
    logic [12:0] r;
    sec = 0;
    ded = 0;
    for (int i = 0; i < M; i++) begin
      a  = src + 8'(2 * i);
      lo = ref_mem[a];
      hi = ref_mem[a + 8'd1];
      if (!m) begin
        out = ref_encode({hi[2:0], lo});
      end else begin
        r   = ref_decode({hi, lo});
        out = {r[12:11], 3'b000, r[10:0]};
        if (r[12:11] == FLAG_SEC && sec != 8'hFF) sec++;
        if (r[12:11] == FLAG_DED && ded != 8'hFF) ded++;
      end
      a = dst + 8'(2 * i);
      ref_mem[a] = out[7:0];
      wq.push_back('{addr: a, data: out[7:0]});
      ref_mem[a + 8'd1] = out[15:8];
      wq.push_back('{addr: a + 8'd1, data: out[15:8]});
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (wq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", bus.mem_addr, bus.mem_wdata);
      end else begin
        wr_t e;
        e = wq.pop_front();
        check("write_addr", bus.mem_addr, e.addr);
        check("write_data", bus.mem_wdata, e.data);
      end
      writes_seen++;
    end
    if (bus.ack === 1'b1) begin
      if (aq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ack: ack high at cycle %0d, none expected", cyc);
      end else begin
        ack_t e;
        e = aq.pop_front();
        check("ack_cycle", cyc, e.cyc);
        check("ack_sec_cnt", bus.sec_cnt, e.sec);
        check("ack_ded_cnt", bus.ded_cnt, e.ded);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    tb_we = 1'b1;
    tb_addr = a;
    tb_data = d;
    tick();
    tb_we = 1'b0;
    ref_mem[a] = d;
  endtask

  function automatic logic [15:0] make_codeword();
    logic [15:0] cw;
    int b1, n;
    cw = ref_encode(11'($urandom));
    n  = $urandom_range(0, 2);
    b1 = $urandom_range(0, 15);
    if (n >= 1) cw[b1] = ~cw[b1];
    if (n == 2) cw[(b1 + $urandom_range(1, 15)) % 16] ^= 1'b1;
    return cw;
  endfunction

  task automatic fill_src(input logic m, input logic [7:0] src);
    logic [15:0] w;
    for (int i = 0; i < M; i++) begin
      w = m ? make_codeword() : 16'($urandom);
      poke(src + 8'(2 * i), w[7:0]);
      poke(src + 8'(2 * i + 1), w[15:8]);
    end
  endtask

  // Request is presented for the edge that follows; k is that edge's index. Ack is then
  // expected in the cycle that starts at edge k + 5*M.
  task automatic start_job(input logic m, input logic [7:0] src, input logic [7:0] dst,
                           input bit hold, output int k);
    logic [7:0] s, d;
    model_job(m, src, dst, s, d);
    bus.req      = 1'b1;
    bus.mode     = m ? MODE_DECODE : MODE_ENCODE;
    bus.src_base = src;
    bus.dst_base = dst;
    tick();
    k = cyc;
    if (!hold) bus.req = 1'b0;
    aq.push_back('{cyc: k + 5 * M, sec: s, ded: d});
    last_sec = s;
    last_ded = d;
    check("busy_after_req", bus.busy, 1);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (aq.size() == 0 && wq.size() == 0 && bus.busy === 1'b0) begin
        ok = 1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL job_timeout: busy %0b, %0d acks and %0d writes outstanding",
               bus.busy, aq.size(), wq.size());
      aq.delete();
      wq.delete();
    end
    repeat (3) tick();
    check("idle_ack_low", bus.ack, 0);
    check("held_sec_cnt", bus.sec_cnt, last_sec);
    check("held_ded_cnt", bus.ded_cnt, last_ded);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  bus.busy, 0);
    check({tag, "_ack"},   bus.ack, 0);
    check({tag, "_we"},    bus.mem_we, 0);
    check({tag, "_addr"},  bus.mem_addr, 0);
    check({tag, "_wdata"}, bus.mem_wdata, 0);
    check({tag, "_sec"},   bus.sec_cnt, 0);
    check({tag, "_ded"},   bus.ded_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] enc_exp [6];
    logic [7:0] dec_exp [6];
    logic [7:0] src, dst;
    logic       m;
    int         k, w0;
    bit         hit;

    enc_exp = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h0F, 8'h00};
    dec_exp = '{8'h01, 8'h40, 8'h01, 8'h40, 8'h01, 8'h80};

    reset = 1'b1;
    tb_we = 1'b0;
    tb_addr = '0;
    tb_data = '0;
    bus.req = 1'b0;
    bus.mode = MODE_ENCODE;
    bus.src_base = '0;
    bus.dst_base = '0;
    repeat (3) tick();
    check_reset_outputs("reset");

    // Reset wins over a simultaneous request.
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    check("reset_beats_req", bus.busy, 0);

    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
    reset = 1'b0;
    tick();

    // Directed encode: 0x000, 0x7FF, 0x001.
    poke(8'd0, 8'h00); poke(8'd1, 8'h00);
    poke(8'd2, 8'hFF); poke(8'd3, 8'h07);
    poke(8'd4, 8'h01); poke(8'd5, 8'h00);
    start_job(1'b0, 8'd0, 8'd30, 0, k);
    wait_done();
    for (int i = 0; i < 6; i++) check("enc_vector_byte", mem[30 + i], enc_exp[i]);
    check("enc_sec_zero", bus.sec_cnt, 0);
    check("enc_ded_zero", bus.ded_cnt, 0);

    // Directed decode: single data error, p16 error, double error.
    poke(8'd64, 8'h2F); poke(8'd65, 8'h00);
    poke(8'd66, 8'h0E); poke(8'd67, 8'h00);
    poke(8'd68, 8'h0C); poke(8'd69, 8'h00);
    start_job(1'b1, 8'd64, 8'd94, 0, k);
    wait_done();
    for (int i = 0; i < 6; i++) check("dec_vector_byte", mem[94 + i], dec_exp[i]);
    check("dec_sec_two", bus.sec_cnt, 2);
    check("dec_ded_one", bus.ded_cnt, 1);

    // Source range wraps past 0xFF.
    fill_src(1'b0, 8'hFE);
    start_job(1'b0, 8'hFE, 8'h40, 0, k);
    wait_done();

    // Overlapping source and destination.
    fill_src(1'b1, 8'h80);
    start_job(1'b1, 8'h80, 8'h81, 0, k);
    wait_done();

    // Randomised jobs.
    for (int j = 0; j < 8; j++) begin
      m   = 1'($urandom);
      src = 8'($urandom);
      dst = 8'($urandom);
      fill_src(m, src);
      start_job(m, src, dst, 0, k);
      wait_done();
    end

    // Requests pulsed while busy are ignored.
    fill_src(1'b1, 8'h10);
    w0 = writes_seen;
    start_job(1'b1, 8'h10, 8'hA0, 0, k);
    for (int p = 0; p < 3; p++) begin
      repeat ($urandom_range(1, 2)) tick();
      bus.req = 1'b1;
      bus.mode = (p % 2 == 0) ? MODE_ENCODE : MODE_DECODE;
      bus.src_base = 8'($urandom);
      tick();
      bus.req = 1'b0;
    end
    wait_done();
    check("writes_per_job", writes_seen - w0, 2 * M);

    // Request held through DONE: second job accepted in the IDLE cycle after DONE.
    fill_src(1'b0, 8'h20);
    start_job(1'b0, 8'h20, 8'h50, 1, k);
    begin
      logic [7:0] s2, d2;
      model_job(1'b0, 8'h20, 8'h50, s2, d2);
      aq.push_back('{cyc: k + 10 * M + 2, sec: s2, ded: d2});
    end
    while (cyc < k + 5 * M + 2) tick();
    bus.req = 1'b0;
    check("held_req_restart", bus.busy, 1);
    wait_done();

    // Reset during WRL of message 2: no further writes, no ack.
    fill_src(1'b1, 8'hC0);
    w0 = writes_seen;
    start_job(1'b1, 8'hC0, 8'hD0, 0, k);
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.mem_we === 1'b1 && writes_seen - w0 == 4) begin
        hit = 1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL reset_point: WRL of message 2 not reached, writes %0d", writes_seen - w0);
    end
    reset = 1'b1;
    tick();
    wq.delete();
    aq.delete();
    check_reset_outputs("abort");
    tick();
    reset = 1'b0;
    repeat (4) tick();
    check_reset_outputs("post_abort");
    check("abort_writes", writes_seen - w0, 5);
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

    fill_src(1'b1, 8'hC0);
    start_job(1'b1, 8'hC0, 8'hD0, 0, k);
    wait_done();

    check("leftover_writes", wq.size(), 0);
    check("leftover_acks", aq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
